// File: rtl/subtractor_32bit_serial.sv
// Multi-cycle unsigned subtractor: diff = num1 - num2 - B_in, one SLICE_W-bit slice per cycle.
// Borrow ripples slice to slice through a register; operands and result use valid/ready handshakes.
// Optional feature macro: SUB_OVF_EN adds the registered signed-overflow output ovf.
module subtractor_32bit_serial #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             B_out
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NS    = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned SUM_W = SLICE_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    // Operand width must split evenly into slices
    if ((WIDTH % SLICE_W) != 0) begin : g_width_check
        $error("subtractor_32bit_serial: WIDTH must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               borrow;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SUM_W-1:0]   slice_sum;
    logic [WIDTH-1:0]   acc_next;

    // Current slice: a + ~b + ~borrow; carry-out low means a borrow into the next slice
    always_comb begin
        a_slice   = a_reg[32'(idx) * SLICE_W +: SLICE_W];
        b_slice   = b_reg[32'(idx) * SLICE_W +: SLICE_W];
        slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE_W{1'b0}}, ~borrow};
        acc_next  = acc;
        acc_next[32'(idx) * SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
    end

    // Control FSM and datapath registers; results update only when the last slice completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            borrow    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            B_out     <= 1'b0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= num1;
                        b_reg    <= num2;
                        borrow   <= B_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    borrow <= ~slice_sum[SLICE_W];
                    if (idx == LAST_IDX) begin
                        diff      <= acc_next;
                        B_out     <= ~slice_sum[SLICE_W];
`ifdef SUB_OVF_EN
                        ovf       <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                                     (a_reg[WIDTH-1] ^ slice_sum[SLICE_W-1]);
`endif
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Self-checking bench for subtractor_32bit_serial (optionally built with SUB_OVF_EN).
module tb_subtractor_32bit_serial;

    localparam int unsigned WIDTH = 32;
    localparam int EXP_LAT = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             B_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             B_out;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    subtractor_32bit_serial #(.WIDTH(32), .SLICE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .B_in      (B_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .B_out     (B_out)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width subtraction with a 33rd bit catching the borrow
    function automatic logic [WIDTH:0] model_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic bin);
        return {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ d[WIDTH-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one full transaction; returns result and accept-to-valid latency in cycles
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          output logic [WIDTH-1:0] d, output logic bo, output logic ov,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        num1 = a;
        num2 = b;
        B_in = bin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        num1 = $urandom;
        num2 = $urandom;
        B_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        d  = diff;
        bo = B_out;
`ifdef SUB_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        num1 = '0;
        num2 = '0;
        B_in = 1'b0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (diff !== '0 || B_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: diff=%h B_out=%b expected 0/0", diff, B_out);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: ovf=%b expected 0", ovf);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [5];
        logic [WIDTH-1:0] vb [5];
        logic             vbin [5];
        logic [WIDTH-1:0] vd [5];
        logic             vbo [5];
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; vbin[0] = 1'b0; vd[0] = 32'h0000_0002; vbo[0] = 1'b0;
        va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001; vbin[1] = 1'b0; vd[1] = 32'hFFFF_FFFF; vbo[1] = 1'b1;
        va[2] = 32'h0100_0000; vb[2] = 32'h0000_0001; vbin[2] = 1'b0; vd[2] = 32'h00FF_FFFF; vbo[2] = 1'b0;
        va[3] = 32'h0000_0010; vb[3] = 32'h0000_0010; vbin[3] = 1'b1; vd[3] = 32'hFFFF_FFFF; vbo[3] = 1'b1;
        va[4] = 32'hFFFF_FFFF; vb[4] = 32'hFFFF_FFFF; vbin[4] = 1'b0; vd[4] = 32'h0000_0000; vbo[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vbin[i], d, bo, ov, lat);
            checks++;
            if (d !== vd[i] || bo !== vbo[i]) begin
                failures++;
                $display("FAIL directed_%0d: diff=%h B_out=%b expected %h/%b", i, d, bo, vd[i], vbo[i]);
            end
            checks++;
            if (lat != EXP_LAT) begin
                failures++;
                $display("FAIL directed_lat_%0d: latency=%0d expected %0d", i, lat, EXP_LAT);
            end
        end
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [WIDTH-1:0] vd [3];
        logic             vov [3];
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        va[0] = 32'h8000_0000; vb[0] = 32'h0000_0001; vd[0] = 32'h7FFF_FFFF; vov[0] = 1'b1;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'hFFFF_FFFF; vd[1] = 32'h8000_0000; vov[1] = 1'b1;
        va[2] = 32'h0000_0005; vb[2] = 32'h0000_0003; vd[2] = 32'h0000_0002; vov[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, d, bo, ov, lat);
            checks++;
            if (d !== vd[i] || ov !== vov[i]) begin
                failures++;
                $display("FAIL ovf_%0d: diff=%h ovf=%b expected %h/%b", i, d, ov, vd[i], vov[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] a, b, d;
        logic bin, bo, ov;
        logic [WIDTH:0] exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = a;
            if (i % 7 == 0) a = WIDTH'(a & 32'h0000_00FF);
            bin = 1'($urandom);
            exp = model_sub(a, b, bin);
            run_op(a, b, bin, d, bo, ov, lat);
            checks++;
            if (d !== exp[WIDTH-1:0] || bo !== exp[WIDTH] || lat != EXP_LAT) begin
                failures++;
                $display("FAIL random_%0d: %h-%h-%b got diff=%h B_out=%b lat=%0d expected %h/%b/%0d",
                         i, a, b, bin, d, bo, lat, exp[WIDTH-1:0], exp[WIDTH], EXP_LAT);
            end
`ifdef SUB_OVF_EN
            checks++;
            if (ov !== model_ovf(a, b, exp[WIDTH-1:0])) begin
                failures++;
                $display("FAIL random_ovf_%0d: ovf=%b expected %b", i, ov, model_ovf(a, b, exp[WIDTH-1:0]));
            end
`endif
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] a, b, d;
        logic bo, ov;
        logic [WIDTH:0] exp;
        int w;
        a = 32'h1234_5678;
        b = 32'h2345_6789;
        exp = model_sub(a, b, 1'b1);
        num1 = a;
        num2 = b;
        B_in = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        // Hold off the consumer while offering new operands
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            num1 = $urandom;
            num2 = $urandom;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp[WIDTH-1:0] || B_out !== exp[WIDTH]) begin
                failures++;
                $display("FAIL stall_%0d: out_valid=%b in_ready=%b diff=%h B_out=%b expected 1/0/%h/%b",
                         i, out_valid, in_ready, diff, B_out, exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        exp = model_sub(a, b, 1'b0);
        run_op(a, b, 1'b0, d, bo, ov, w);
        checks++;
        if (d !== exp[WIDTH-1:0] || bo !== exp[WIDTH]) begin
            failures++;
            $display("FAIL stall_next: diff=%h B_out=%b expected %h/%b", d, bo, exp[WIDTH-1:0], exp[WIDTH]);
        end
    endtask

    task automatic test_reset_midcalc();
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        num1 = 32'h0000_0001;
        num2 = 32'h0000_0002;
        B_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || B_out !== 1'b0) begin
            failures++;
            $display("FAIL midcalc_reset: in_ready=%b out_valid=%b diff=%h B_out=%b expected 1/0/0/0",
                     in_ready, out_valid, diff, B_out);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midcalc_ghost_%0d: out_valid=%b expected 0", i, out_valid);
            end
        end
        run_op(32'h0000_0009, 32'h0000_0004, 1'b0, d, bo, ov, lat);
        checks++;
        if (d !== 32'h0000_0005 || bo !== 1'b0 || lat != EXP_LAT) begin
            failures++;
            $display("FAIL midcalc_fresh: diff=%h B_out=%b lat=%0d expected 00000005/0/%0d", d, bo, lat, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b, d;
        logic bo, ov;
        logic [WIDTH:0] exp;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            exp = model_sub(a, b, 1'b0);
            run_op(a, b, 1'b0, d, bo, ov, lat);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready_%0d: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
            checks++;
            if (d !== exp[WIDTH-1:0] || bo !== exp[WIDTH]) begin
                failures++;
                $display("FAIL b2b_data_%0d: diff=%h B_out=%b expected %h/%b", i, d, bo, exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        test_stall();
        test_reset_midcalc();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
